// File: rtl/seq_detector_fsm.sv
// Serial pattern detector: tracks the longest matched prefix of PATTERN with KMP-style fallback.
// Optional idle abort is compiled in with `define SEQ_DET_TIMEOUT_EN.
module seq_detector_fsm #(
  parameter int               PAT_W   = 4,
  parameter logic [PAT_W-1:0] PATTERN = 4'b1011,
  parameter bit               OVERLAP = 1'b1,
  parameter int               CNT_W   = 8,
  parameter int               TIMEOUT = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  input  logic                     in,
  input  logic                     cnt_clr,
  output logic [$clog2(PAT_W)-1:0] state,
  output logic                     out,
  output logic [CNT_W-1:0]         match_count,
  output logic                     timeout
);

  localparam int SW = $clog2(PAT_W);

  logic [PAT_W-2:0] hist_q, hist_d;
  logic [PAT_W-1:0] win, mask;
  logic [SW-1:0]    state_d, best;
  logic [CNT_W-1:0] cnt_d;
  logic             full, match, abort;

`ifdef SEQ_DET_TIMEOUT_EN
  localparam int IW = $clog2(TIMEOUT + 1);
  logic [IW-1:0] idle_q, idle_d;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= '0;
      hist_q      <= '0;
      out         <= 1'b0;
      match_count <= '0;
    end else begin
      state       <= state_d;
      hist_q      <= hist_d;
      out         <= match;
      match_count <= cnt_d;
    end
  end

  // The window is the last PAT_W-1 accepted bits plus the incoming one. Candidate
  // lengths are capped at k+1 so stale history older than the current match never counts.
  always_comb begin
    win  = {hist_q, in};
    full = (state == SW'(PAT_W - 1)) && (in == PATTERN[0]);
    best = '0;
    mask = '0;
    for (int l = 1; l < PAT_W; l++) begin
      mask = (PAT_W'(1) << l) - PAT_W'(1);
      if ((l <= int'(state) + 1) && ((win & mask) == ((PATTERN >> (PAT_W - l)) & mask)))
        best = SW'(l);
    end
  end

  always_comb begin
    state_d = state;
    hist_d  = hist_q;
    match   = 1'b0;
    abort   = 1'b0;
    if (in_valid) begin
      hist_d  = win[PAT_W-2:0];
      state_d = best;
      match   = full;
      if (full && !OVERLAP) begin
        state_d = '0;
        hist_d  = '0;
      end
    end
`ifdef SEQ_DET_TIMEOUT_EN
    else if ((state != '0) && (idle_q == IW'(TIMEOUT - 1))) begin
      abort   = 1'b1;
      state_d = '0;
      hist_d  = '0;
    end
`endif
  end

  // A clear coincident with a match keeps that match.
  always_comb begin
    cnt_d = match_count;
    if (cnt_clr)
      cnt_d = match ? CNT_W'(1) : '0;
    else if (match && (match_count != '1))
      cnt_d = match_count + CNT_W'(1);
  end

`ifdef SEQ_DET_TIMEOUT_EN
  always_comb begin
    if (in_valid || (state == '0) || abort) idle_d = '0;
    else                                     idle_d = idle_q + IW'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      idle_q  <= '0;
      timeout <= 1'b0;
    end else begin
      idle_q  <= idle_d;
      timeout <= abort;
    end
  end
`else
  assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_seq_detector_fsm.sv
// Bench for seq_detector_fsm: table rows through a scoreboard queue, three configurations side by side.
module tb_seq_detector_fsm;

  typedef struct {
    logic       r, v, b, clr;
    logic [1:0] st;
    logic       o;
    logic       cn;
    logic [1:0] sn;
    logic       on;
  } vec_t;

  logic clk = 1'b0;
  logic reset = 1'b1, in_valid = 1'b0, in = 1'b0, cnt_clr = 1'b0;
  logic [1:0] st_a, st_no, st_c2;
  logic       out_a, out_no, out_c2, to_a, to_no, to_c2;
  logic [7:0] cnt_a, cnt_no;
  logic [1:0] cnt_c2;

  int checks = 0;
  int errors = 0;
  vec_t tbl[$];
  vec_t exp_q[$];

  always #5 clk = ~clk;

  seq_detector_fsm #(.TIMEOUT(4)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in(in), .cnt_clr(cnt_clr),
    .state(st_a), .out(out_a), .match_count(cnt_a), .timeout(to_a));

  seq_detector_fsm #(.OVERLAP(1'b0), .TIMEOUT(4)) dut_no (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in(in), .cnt_clr(cnt_clr),
    .state(st_no), .out(out_no), .match_count(cnt_no), .timeout(to_no));

  seq_detector_fsm #(.CNT_W(2), .TIMEOUT(4)) dut_c2 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in(in), .cnt_clr(cnt_clr),
    .state(st_c2), .out(out_c2), .match_count(cnt_c2), .timeout(to_c2));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic add(input logic r, v, b, clr, input logic [1:0] st, input logic o,
                     input logic cn, input logic [1:0] sn, input logic on);
    vec_t t;
    t.r = r; t.v = v; t.b = b; t.clr = clr; t.st = st; t.o = o;
    t.cn = cn; t.sn = sn; t.on = on;
    tbl.push_back(t);
  endtask

  task automatic apply(input vec_t t);
    vec_t e;
    reset = t.r; in_valid = t.v; in = t.b; cnt_clr = t.clr;
    exp_q.push_back(t);
    @(posedge clk); #1;
    e = exp_q.pop_front();
    chk("state", 32'(st_a), 32'(e.st));
    chk("out", 32'(out_a), 32'(e.o));
    if (e.cn) begin
      chk("state_nonoverlap", 32'(st_no), 32'(e.sn));
      chk("out_nonoverlap", 32'(out_no), 32'(e.on));
    end
  endtask

  task automatic run();
    foreach (tbl[i]) apply(tbl[i]);
    tbl.delete();
  endtask

  task automatic bit_row(input logic b, input logic [1:0] st, input logic o);
    add(0, 1, b, 0, st, o, 0, 0, 0);
  endtask

  initial begin
    // reset held two cycles
    add(1, 1, 1, 0, 0, 0, 1, 0, 0);
    add(1, 1, 1, 0, 0, 0, 1, 0, 0);
    run();
    chk("reset_count", 32'(cnt_a), 0);
    chk("reset_timeout", 32'(to_a), 0);

    // basic match 1011
    add(0, 1, 1, 0, 1, 0, 1, 1, 0);
    add(0, 1, 0, 0, 2, 0, 1, 2, 0);
    add(0, 1, 1, 0, 3, 0, 1, 3, 0);
    add(0, 1, 1, 0, 1, 1, 1, 0, 1);
    add(0, 0, 1, 0, 1, 0, 1, 0, 0);
    run();
    chk("basic_count", 32'(cnt_a), 1);
    chk("basic_count_nonoverlap", 32'(cnt_no), 1);

    // overlap vs non-overlap: 1011011
    add(1, 0, 0, 0, 0, 0, 1, 0, 0);
    add(0, 1, 1, 0, 1, 0, 1, 1, 0);
    add(0, 1, 0, 0, 2, 0, 1, 2, 0);
    add(0, 1, 1, 0, 3, 0, 1, 3, 0);
    add(0, 1, 1, 0, 1, 1, 1, 0, 1);
    add(0, 1, 0, 0, 2, 0, 1, 0, 0);
    add(0, 1, 1, 0, 3, 0, 1, 1, 0);
    add(0, 1, 1, 0, 1, 1, 1, 1, 0);
    run();
    chk("overlap_count", 32'(cnt_a), 2);
    chk("nonoverlap_count", 32'(cnt_no), 1);

    // fallback 11 -> 1, gaps hold state
    add(1, 0, 0, 0, 0, 0, 1, 0, 0);
    add(0, 1, 1, 0, 1, 0, 1, 1, 0);
    add(0, 0, 0, 0, 1, 0, 1, 1, 0);
    add(0, 1, 1, 0, 1, 0, 1, 1, 0);
    add(0, 0, 1, 0, 1, 0, 1, 1, 0);
    add(0, 1, 0, 0, 2, 0, 1, 2, 0);
    add(0, 0, 1, 0, 2, 0, 1, 2, 0);
    add(0, 1, 1, 0, 3, 0, 1, 3, 0);
    add(0, 0, 0, 0, 3, 0, 1, 3, 0);
    add(0, 1, 1, 0, 1, 1, 1, 0, 1);
    add(0, 0, 1, 0, 1, 0, 1, 0, 0);
    run();
    chk("gap_count", 32'(cnt_a), 1);

    // reset mid-match overrides a would-be completing bit
    add(0, 1, 0, 0, 2, 0, 1, 0, 0);
    add(0, 1, 1, 0, 3, 0, 1, 1, 0);
    add(1, 1, 1, 0, 0, 0, 1, 0, 0);
    add(1, 1, 1, 0, 0, 0, 1, 0, 0);
    add(0, 1, 1, 0, 1, 0, 1, 1, 0);
    run();
    chk("midreset_count", 32'(cnt_a), 0);
    chk("midreset_count_c2", 32'(cnt_c2), 0);

    // saturation on the 2-bit counter: five overlapping matches
    add(1, 0, 0, 0, 0, 0, 0, 0, 0);
    bit_row(1, 1, 0); bit_row(0, 2, 0); bit_row(1, 3, 0); bit_row(1, 1, 1);
    for (int m = 0; m < 2; m++) begin
      bit_row(0, 2, 0); bit_row(1, 3, 0); bit_row(1, 1, 1);
    end
    run();
    chk("sat_count_3", 32'(cnt_c2), 3);
    for (int m = 0; m < 2; m++) begin
      bit_row(0, 2, 0); bit_row(1, 3, 0); bit_row(1, 1, 1);
    end
    run();
    chk("sat_count_c2", 32'(cnt_c2), 3);
    chk("count_5", 32'(cnt_a), 5);

    // clear coincident with a match loads 1, clear alone loads 0
    bit_row(0, 2, 0); bit_row(1, 3, 0);
    add(0, 1, 1, 1, 1, 1, 0, 0, 0);
    run();
    chk("clr_match", 32'(cnt_a), 1);
    chk("clr_match_c2", 32'(cnt_c2), 1);
    add(0, 0, 0, 1, 1, 0, 0, 0, 0);
    run();
    chk("clr_alone", 32'(cnt_a), 0);
    chk("clr_alone_c2", 32'(cnt_c2), 0);

    // idle abort
    add(1, 0, 0, 0, 0, 0, 0, 0, 0);
    bit_row(1, 1, 0); bit_row(0, 2, 0);
    run();
    for (int i = 0; i < 5; i++) begin
      vec_t t;
      logic [1:0] es;
      logic       eto;
`ifdef SEQ_DET_TIMEOUT_EN
      es  = (i < 3) ? 2'd2 : 2'd0;
      eto = (i == 3);
`else
      es  = 2'd2;
      eto = 1'b0;
`endif
      t.r = 0; t.v = 0; t.b = 1; t.clr = 0; t.st = es; t.o = 0;
      t.cn = 0; t.sn = 0; t.on = 0;
      apply(t);
      chk("timeout", 32'(to_a), 32'(eto));
    end
    chk("timeout_count", 32'(cnt_a), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
